// File: rtl/systolic_wgt_loader.sv
// Weight-path loader for the systolic PE array.
// Collects one ARRAY_M x ARRAY_N weight tile from a valid/ready stream and
// bursts it into the shadow b_path chain of the top PE row, last row first.
// It then waits for the enable wave to settle and issues a one-cycle b_en
// commit on request. The next tile can preload while the array computes.
module systolic_wgt_loader #(
  parameter int WGT_DATA_WIDTH = 8,
  parameter int ARRAY_N        = 4,
  parameter int ARRAY_M        = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wgt_valid,
  output logic                              wgt_ready,
  input  logic [ARRAY_N*WGT_DATA_WIDTH-1:0] wgt_data,
  input  logic                              commit_req,
  output logic                              b_path_en,
  output logic [ARRAY_N*WGT_DATA_WIDTH-1:0] b_path_data,
  output logic                              b_en,
  output logic                              loaded,
  output logic                              busy
);

  localparam int RW = ARRAY_N * WGT_DATA_WIDTH;
  localparam int IW = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;
  localparam int SW = $clog2(ARRAY_M + 2);

  localparam logic [IW-1:0] LAST_IDX    = IW'(ARRAY_M - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(ARRAY_M);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    BURST  = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [RW-1:0]  row_buf [ARRAY_M];
  logic [IW-1:0]  beat_cnt;
  logic [IW-1:0]  burst_cnt;
  logic [SW-1:0]  settle_cnt;
  logic           beat_acc;

  assign beat_acc = wgt_valid && wgt_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: load -> burst -> settle -> hold -> commit.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (beat_acc) begin
          state_nxt = (beat_cnt == LAST_IDX) ? BURST : LOAD;
        end
      end
      BURST: begin
        if (burst_cnt == LAST_IDX) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        if (commit_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: handshake, shift enable, commit pulse and status.
  always_comb begin
    wgt_ready = 1'b0;
    b_path_en = 1'b0;
    b_en      = 1'b0;
    loaded    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE, LOAD: wgt_ready = !reset;
      BURST:      b_path_en = 1'b1;
      HOLD: begin
        b_en   = commit_req;
        loaded = !commit_req;
      end
      default: ;
    endcase
  end

  // Beat, burst and settle counters plus the registered chain data.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt    <= '0;
      burst_cnt   <= '0;
      settle_cnt  <= '0;
      b_path_data <= '0;
    end else begin
      if (beat_acc) begin
        beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + IW'(1);
      end
      if (state == BURST) begin
        // Lags b_path_en by one cycle to line up with the PE's registered enable.
        b_path_data <= row_buf[LAST_IDX - burst_cnt];
        burst_cnt   <= (burst_cnt == LAST_IDX) ? '0 : burst_cnt + IW'(1);
      end
      if (state == SETTLE) begin
        settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + SW'(1);
      end
    end
  end

  // Row buffer write on each accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; every entry is rewritten before it is read.
    if (beat_acc) begin
      row_buf[beat_cnt] <= wgt_data;
    end
  end

endmodule

// File: doc/systolic_wgt_loader.md
Name: systolic_wgt_loader

Overview:
- Upstream stage of the PE array's weight path.
- Collects one full weight tile (ARRAY_M rows × ARRAY_N columns) from a valid/ready stream and buffers it.
- Bursts the tile into the top row of the array over the shadow b_path chain, then waits for the chain to settle.
- On request, issues the commit pulse (b_en) that copies the shadow weights into the active weight registers, so the next tile can preload while the array computes.

Parameters:
- WGT_DATA_WIDTH, 8, bits per weight.
- ARRAY_N, 4, array columns (weights per row beat).
- ARRAY_M, 4, array rows (beats per tile).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wgt_valid  in  1  stream beat valid.
- wgt_ready  out  1  stream beat accepted when wgt_valid && wgt_ready.
- wgt_data  in  ARRAY_N*WGT_DATA_WIDTH  one weight row; column c at bits [c*W +: W].
- commit_req  in  1  level request to commit the loaded tile.
- b_path_en  out  1  shadow-chain shift enable into the top PE row (shared by all columns).
- b_path_data  out  ARRAY_N*WGT_DATA_WIDTH  shadow-chain data into the top PE row.
- b_en  out  1  one-cycle commit pulse into the top PE row.
- loaded  out  1  tile is resident in the shadow chain and not yet committed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state = IDLE; beat counter = 0; settle counter = 0.
  - Outputs after reset: wgt_ready=0, b_path_en=0, b_path_data=0, b_en=0, loaded=0, busy=0.
  - The row buffer contents are don't-care.
  - Reset mid-burst aborts the load. The shadow contents are then undefined, and no b_en is issued.
- State machine: IDLE -> LOAD -> BURST -> SETTLE -> HOLD -> IDLE.
- IDLE:
  - wgt_ready=1.
  - An accepted beat is written to buffer[0], beat counter becomes 1, and the state moves to LOAD.
- LOAD:
  - wgt_ready=1.
  - Each accepted beat k is written to buffer[k].
  - On acceptance of beat ARRAY_M-1, the state moves to BURST with the burst counter set to 0.
  - Gaps in wgt_valid are allowed.
- BURST:
  - wgt_ready=0.
  - b_path_en=1 for exactly ARRAY_M consecutive cycles.
  - b_path_data is registered and lags b_path_en by one cycle. In the cycle after the j-th b_path_en cycle (j=0..ARRAY_M-1), b_path_data = buffer[ARRAY_M-1-j]. This matches the PE's registered enable, so the last tile row enters first.
  - After the final enable cycle, the state moves to SETTLE with the settle counter set to 0.
  - b_path_data holds its last value until the next burst.
- SETTLE:
  - Counts ARRAY_M+1 cycles. This lets the enable wave reach row ARRAY_M-1 and freeze it.
  - The state then moves to HOLD.
  - Resulting placement: beat k resides in row k.
- HOLD:
  - loaded=1; wgt_ready=0.
  - When commit_req=1, assert b_en for exactly one cycle, deassert loaded in the same cycle, and move to IDLE.
  - commit_req asserted before HOLD is ignored until HOLD is reached. A level held high commits once on HOLD entry.
- Simultaneous events:
  - commit_req while in IDLE/LOAD/BURST/SETTLE has no effect.
  - wgt_valid in BURST/SETTLE/HOLD is not accepted (wgt_ready=0).
- Throughput: a new tile may begin loading in the cycle after b_en.
- Minimum tile-to-commit latency: ARRAY_M accepted beats + ARRAY_M burst + ARRAY_M+1 settle cycles, then one cycle to b_en once commit_req is seen in HOLD.
- The data path is pure movement: no arithmetic, no width change, no sign handling.

Test Plan:
- Reset, then 4 back-to-back beats (M=N=4, rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D) -> b_path_en high 4 cycles, and b_path_data one cycle later = 0x100F0E0D, 0x0C0B0A09, 0x08070605, 0x04030201. After the 5-cycle settle, loaded=1. With commit_req=1, b_en pulses 1 cycle and row r of a PE-array model holds beat r.
- Beats with wgt_valid gaps (valid 1,0,0,1,1,0,1) -> exactly 4 beats accepted, burst identical to the back-to-back case, no b_path_en during gaps.
- commit_req held high from cycle 0 -> no b_en before HOLD; exactly one b_en cycle per tile. Second tile accepted starting the cycle after b_en.
- wgt_valid held high through BURST/SETTLE/HOLD -> wgt_ready=0 throughout; extra beats are not consumed until IDLE.
- reset asserted on 2nd BURST cycle -> next cycle all outputs zero, busy=0, no b_en. A fresh tile then loads correctly.
- Parameter sweep ARRAY_M=1, ARRAY_N=1, WGT_DATA_WIDTH=16 -> single-beat burst, 2-cycle settle, correct commit.
